// File: rtl/serial_comparator_framed_if.sv
// Digit-stream interface for the framed serial comparator.
// master drives digits and control, slave (the comparator) returns results.
interface serial_comparator_framed_if #(
  parameter int DIGIT_W = 1
);
  logic               in_valid;
  logic [DIGIT_W-1:0] a;
  logic [DIGIT_W-1:0] b;
  logic               msb_first;
  logic               is_signed;
  logic               clear;
  logic               busy;
  logic               res_valid;
  logic               a_less_b;
  logic               a_eq_b;
  logic               a_greater_b;

  modport master (
    output in_valid, a, b, msb_first, is_signed, clear,
    input  busy, res_valid, a_less_b, a_eq_b, a_greater_b
  );

  modport slave (
    input  in_valid, a, b, msb_first, is_signed, clear,
    output busy, res_valid, a_less_b, a_eq_b, a_greater_b
  );
endinterface

// File: rtl/serial_comparator_framed.sv
// Serial magnitude comparator with word framing.
// Accepts one digit pair per cycle, WORD_DIGITS digits per word, and emits a
// registered less/equal/greater result with a one-cycle valid pulse per word.
// Digit order and signedness are latched from the first digit of each word.
module serial_comparator_framed #(
  parameter int DIGIT_W     = 1,
  parameter int WORD_DIGITS = 8
) (
  input logic                 clk,
  input logic                 rst,
  serial_comparator_framed_if.slave bus
);
  localparam int            CW   = (WORD_DIGITS > 1) ? $clog2(WORD_DIGITS) : 1;
  localparam logic [CW-1:0] LAST = CW'(WORD_DIGITS - 1);

  logic [CW-1:0]      cnt;
  logic               msb_q, sgn_q;
  logic               eq, lt;
  logic               vld_q, lt_f, eq_f, gt_f;

  logic               mode_msb, mode_sgn, sign_dig;
  logic [DIGIT_W-1:0] da, db;
  logic               eq_n, lt_n;

  // Effective mode, sign-digit bias and next running compare state.
  // MSB-first: first difference wins. LSB-first: latest difference wins.
  always_comb begin
    mode_msb = (cnt == '0) ? bus.msb_first : msb_q;
    mode_sgn = (cnt == '0) ? bus.is_signed : sgn_q;
    sign_dig = mode_msb ? (cnt == '0) : (cnt == LAST);
    da = bus.a;
    db = bus.b;
    if (mode_sgn && sign_dig) begin
      da[DIGIT_W-1] = ~da[DIGIT_W-1];
      db[DIGIT_W-1] = ~db[DIGIT_W-1];
    end
    eq_n = eq;
    lt_n = lt;
    if ((!mode_msb || eq) && (da != db)) begin
      eq_n = 1'b0;
      lt_n = (da < db);
    end
  end

  // Digit counter, mode latch, running state and registered result flags.
  // Priority: rst, then clear, then in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      msb_q <= 1'b0;
      sgn_q <= 1'b0;
      eq    <= 1'b1;
      lt    <= 1'b0;
      vld_q <= 1'b0;
      lt_f  <= 1'b0;
      eq_f  <= 1'b1;
      gt_f  <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (bus.clear) begin
        cnt <= '0;
        eq  <= 1'b1;
        lt  <= 1'b0;
      end else if (bus.in_valid) begin
        if (cnt == '0) begin
          msb_q <= bus.msb_first;
          sgn_q <= bus.is_signed;
        end
        if (cnt == LAST) begin
          cnt   <= '0;
          eq    <= 1'b1;
          lt    <= 1'b0;
          vld_q <= 1'b1;
          eq_f  <= eq_n;
          lt_f  <= lt_n & ~eq_n;
          gt_f  <= ~lt_n & ~eq_n;
        end else begin
          cnt <= cnt + CW'(1);
          eq  <= eq_n;
          lt  <= lt_n;
        end
      end
    end
  end

  assign bus.busy        = (cnt != '0);
  assign bus.res_valid   = vld_q;
  assign bus.a_less_b    = lt_f;
  assign bus.a_eq_b      = eq_f;
  assign bus.a_greater_b = gt_f;
endmodule

// File: tb/tb_serial_comparator_framed.sv
// Randomised and directed bench for serial_comparator_framed (DIGIT_W=2,
// WORD_DIGITS=4). The reference model rebuilds whole 8-bit operands from
// the digits of a word and compares them arithmetically.
module tb_serial_comparator_framed;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  serial_comparator_framed_if #(.DIGIT_W(2)) bus ();

  serial_comparator_framed #(.DIGIT_W(2), .WORD_DIGITS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  int         m_cnt;
  logic       m_msb, m_sgn;
  logic [1:0] qa [4];
  logic [1:0] qb [4];
  logic       e_rv, e_lt, e_eq, e_gt;
  int         words_done = 0;
  int         rv_seen    = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs();
    chk("res_valid", bus.res_valid, e_rv);
    chk("busy", bus.busy, (m_cnt != 0));
    chk("a_less_b", bus.a_less_b, e_lt);
    chk("a_eq_b", bus.a_eq_b, e_eq);
    chk("a_greater_b", bus.a_greater_b, e_gt);
  endtask

  // Whole-word compare of the collected digits.
  task automatic model_finish();
    logic [7:0] wa, wb;
    logic       l;
    wa = '0;
    wb = '0;
    for (int k = 0; k < 4; k++) begin
      if (m_msb) begin
        wa = {wa[5:0], qa[k]};
        wb = {wb[5:0], qb[k]};
      end else begin
        wa[2*k +: 2] = qa[k];
        wb[2*k +: 2] = qb[k];
      end
    end
    l    = m_sgn ? ($signed(wa) < $signed(wb)) : (wa < wb);
    e_eq = (wa == wb);
    e_lt = l && !e_eq;
    e_gt = !l && !e_eq;
    e_rv = 1'b1;
    words_done++;
  endtask

  // One clock cycle: drive inputs, advance model, check outputs.
  task automatic cyc(input logic iv, input logic [1:0] da, input logic [1:0] db,
                     input logic m, input logic s, input logic c);
    bus.in_valid  = iv;
    bus.a         = da;
    bus.b         = db;
    bus.msb_first = m;
    bus.is_signed = s;
    bus.clear     = c;
    @(posedge clk);
    e_rv = 1'b0;
    if (c) begin
      m_cnt = 0;
    end else if (iv) begin
      if (m_cnt == 0) begin
        m_msb = m;
        m_sgn = s;
      end
      qa[m_cnt] = da;
      qb[m_cnt] = db;
      m_cnt++;
      if (m_cnt == 4) begin
        m_cnt = 0;
        model_finish();
      end
    end
    #1;
    if (bus.res_valid === 1'b1) rv_seen++;
    check_outs();
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.clear     = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.msb_first = 1'b0;
    bus.is_signed = 1'b0;
    @(posedge clk);
    m_cnt = 0;
    e_rv  = 1'b0;
    e_lt  = 1'b0;
    e_eq  = 1'b1;
    e_gt  = 1'b0;
    #1;
    rst = 1'b0;
    check_outs();
  endtask

  task automatic idle();
    cyc(1'b0, 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'b0);
  endtask

  // Send one 8-bit word. flip toggles msb_first after the first digit;
  // gaps inserts random idle cycles before digits.
  task automatic send_word(input logic [7:0] av, input logic [7:0] bv, input logic m,
                           input logic s, input logic flip, input logic gaps);
    int idx;
    for (int k = 0; k < 4; k++) begin
      while (gaps && ($urandom_range(0, 2) == 0)) idle();
      idx = m ? (3 - k) : k;
      cyc(1'b1, av[2*idx +: 2], bv[2*idx +: 2], (flip && k > 0) ? ~m : m, s, 1'b0);
    end
  endtask

  initial begin
    logic [7:0] ra, rb;
    bus.in_valid  = 1'b0;
    bus.clear     = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.msb_first = 1'b0;
    bus.is_signed = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) idle();

    // MSB-first unsigned
    send_word(8'hA5, 8'hA3, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("msb_gt", {bus.res_valid, bus.a_greater_b}, 2'b11);
    send_word(8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("msb_eq", {bus.res_valid, bus.a_eq_b}, 2'b11);

    // LSB-first, last digit dominates; then msb_first wiggled mid-word
    send_word(8'h35, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("lsb_lt", {bus.res_valid, bus.a_less_b}, 2'b11);
    send_word(8'h35, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("lsb_flip_lt", {bus.res_valid, bus.a_less_b}, 2'b11);
    idle();
    chk("flags_hold", bus.a_less_b, 1'b1);

    // Signed vs unsigned 0x80 / 0x7F
    send_word(8'h80, 8'h7F, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("sgn_msb_lt", bus.a_less_b, 1'b1);
    send_word(8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("sgn_lsb_lt", bus.a_less_b, 1'b1);
    send_word(8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("uns_msb_gt", bus.a_greater_b, 1'b1);
    send_word(8'h80, 8'h7F, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("uns_lsb_gt", bus.a_greater_b, 1'b1);

    // Abort with clear (digit in the same cycle discarded), then 0x01 vs 0x02
    cyc(1'b1, 2'd3, 2'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'd3, 2'd0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'd3, 2'd0, 1'b1, 1'b0, 1'b1);
    chk("clear_busy", bus.busy, 1'b0);
    send_word(8'h01, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("after_clear_lt", {bus.res_valid, bus.a_less_b}, 2'b11);
    cyc(1'b1, 2'd0, 2'd3, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 2'd0, 2'd3, 1'b0, 1'b0, 1'b1);
    send_word(8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-word
    cyc(1'b1, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 2'd2, 2'd1, 1'b1, 1'b0, 1'b0);
    do_reset();
    chk("rst_eq", bus.a_eq_b, 1'b1);
    idle();

    // Random words: gaps, back-to-back, occasional aborted prefixes
    for (int w = 0; w < 60; w++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < $urandom_range(1, 3); k++)
          cyc(1'b1, 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        cyc(1'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      end
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      send_word(ra, rb, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    for (int i = 0; i < 3; i++) idle();
    chk("rv_count", rv_seen, words_done);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
